// File: rtl/hbmc_wfifo_sc.sv
// Single-clock write-data FIFO: host words in, FWFT 16-bit halfwords out.
// Halfwords leave least-significant first; words/flags run on registered state.
module hbmc_wfifo_sc #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 512,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                                          fifo_clk,
    input  logic                                          fifo_rst,
    input  logic                                          fifo_flush,
    input  logic [DATA_WIDTH-1:0]                         fifo_wr_din,
    input  logic [DATA_WIDTH/8-1:0]                       fifo_wr_strb,
    input  logic                                          fifo_wr_ena,
    output logic                                          fifo_wr_full,
    output logic                                          fifo_wr_afull,
    output logic [15:0]                                   fifo_rd_dout,
    output logic [1:0]                                    fifo_rd_strb,
    input  logic                                          fifo_rd_ena,
    output logic                                          fifo_rd_empty,
    output logic [$clog2(DEPTH*(DATA_WIDTH/16)):0]        fifo_rd_count
);

    localparam int R  = DATA_WIDTH / 16;
    localparam int LR = $clog2(R);
    localparam int HW = (R > 1) ? LR : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int SW = DATA_WIDTH / 8;
    localparam int EW = DATA_WIDTH + SW;
    localparam int CW = $clog2(DEPTH * R) + 1;

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   AFULL_W = (AW + 1)'(AFULL_THRESH);
    localparam logic [HW-1:0] LAST_HI = HW'(R - 1);

    if (!(DATA_WIDTH == 16 || DATA_WIDTH == 32 ||
          DATA_WIDTH == 64 || DATA_WIDTH == 128)) begin : g_bad_width
        $error("hbmc_wfifo_sc: DATA_WIDTH must be 16, 32, 64 or 128");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hbmc_wfifo_sc: DEPTH must be a power of two >= 4");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("hbmc_wfifo_sc: AFULL_THRESH must be in 1..DEPTH");
    end

    logic [EW-1:0]   mem [DEPTH];
    logic [AW:0]     wp;
    logic [AW:0]     rp;
    logic [HW-1:0]   hi;
    logic [AW:0]     words;
    logic            full;
    logic            empty;
    logic            wr_acc;
    logic            rd_acc;
    logic            clr;
    logic            last_hw;
    logic [EW-1:0]   head;
    logic [15:0]     dout_c;
    logic [1:0]      strb_c;

    // Wrap bit makes words exact across pointer wrap without special cases.
    assign words   = wp - rp;
    assign full    = (words == DEPTH_W);
    assign empty   = (words == '0);
    assign clr     = fifo_rst | fifo_flush;
    assign wr_acc  = fifo_wr_ena & ~full;
    assign rd_acc  = fifo_rd_ena & ~empty;
    assign last_hw = (hi == LAST_HI);
    assign head    = mem[rp[AW-1:0]];

    always_ff @(posedge fifo_clk) begin
        if (clr) begin
            wp <= '0;
            rp <= '0;
            hi <= '0;
        end else begin
            if (wr_acc) begin
                wp <= wp + 1'b1;
            end
            if (rd_acc) begin
                if (last_hw) begin
                    hi <= '0;
                    rp <= rp + 1'b1;
                end else begin
                    hi <= hi + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (wr_acc && !clr) begin
            mem[wp[AW-1:0]] <= {fifo_wr_strb, fifo_wr_din};
        end
    end

    always_comb begin
        dout_c = '0;
        strb_c = '0;
        if (!empty) begin
            for (int k = 0; k < R; k++) begin
                if (hi == HW'(k)) begin
                    dout_c = head[16*k +: 16];
                    strb_c = head[DATA_WIDTH + 2*k +: 2];
                end
            end
        end
    end

    assign fifo_rd_dout  = dout_c;
    assign fifo_rd_strb  = strb_c;
    assign fifo_rd_empty = empty;
    assign fifo_wr_full  = full;
    assign fifo_wr_afull = (words >= AFULL_W);
    assign fifo_rd_count = (CW'(words) << LR) - CW'(hi);

endmodule
